// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register pair with a 2-cycle multiplier and a
// 33-cycle radix-2 restoring divider. stall holds the pipeline while a
// mul/div is in flight, done pulses for one cycle on completion, and
// MTHI/MTLO style writes (hilowrite) may land in any state.
module hilo_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic [1:0]  hilowrite,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic [4:0]  divCnt_r;
  logic [1:0]  opLatched_r;
  logic [31:0] aLatched_r;
  logic [31:0] bLatched_r;
  logic [31:0] rem_r;        // partial remainder
  logic [31:0] quo_r;        // dividend bits shift out the top, quotient bits shift in

  logic        signedOp_s;
  logic [31:0] divisor_s;
  logic [63:0] extA_s;
  logic [63:0] extB_s;
  logic [63:0] product_s;
  logic [33:0] trial_s;
  logic [31:0] remNext_s;
  logic [31:0] quoNext_s;
  logic [31:0] quoFinal_s;
  logic [31:0] remFinal_s;

  // Two's-complement magnitude; unsigned operands pass through untouched.
  // -2^31 maps to 0x80000000, which is exactly its unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic isSigned);
    if (isSigned && v[31]) begin
      magnitude = 32'd0 - v;
    end else begin
      magnitude = v;
    end
  endfunction

  // Datapath: product, one restoring-division step, sign fix-up and stall.
  always_comb begin
    signedOp_s = ~opLatched_r[0];
    divisor_s  = magnitude(bLatched_r, signedOp_s);

    // Sign-extending to 64 bits makes the low 64 bits of the product
    // correct for both signed and unsigned operands.
    extA_s    = {{32{signedOp_s & aLatched_r[31]}}, aLatched_r};
    extB_s    = {{32{signedOp_s & bLatched_r[31]}}, bLatched_r};
    product_s = extA_s * extB_s;

    // 34-bit trial so a shifted remainder up to 2^33-1 never aliases the sign.
    trial_s = {1'b0, rem_r, quo_r[31]} - {2'b00, divisor_s};
    if (!trial_s[33]) begin
      remNext_s = trial_s[31:0];
      quoNext_s = {quo_r[30:0], 1'b1};
    end else begin
      remNext_s = {rem_r[30:0], quo_r[31]};
      quoNext_s = {quo_r[30:0], 1'b0};
    end

    if (signedOp_s && (aLatched_r[31] ^ bLatched_r[31])) begin
      quoFinal_s = 32'd0 - quoNext_s;
    end else begin
      quoFinal_s = quoNext_s;
    end
    if (signedOp_s && aLatched_r[31]) begin
      remFinal_s = 32'd0 - remNext_s;
    end else begin
      remFinal_s = remNext_s;
    end

    if (rst || flush) begin
      stall = 1'b0;
    end else begin
      stall = ((state_r == IDLE) && start) || (state_r == MUL) || (state_r == DIV);
    end
  end

  // Control FSM plus HI/LO update; a result write overrides a same-cycle hilowrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      divCnt_r    <= 5'd0;
      opLatched_r <= 2'b00;
      aLatched_r  <= 32'd0;
      bLatched_r  <= 32'd0;
      rem_r       <= 32'd0;
      quo_r       <= 32'd0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      done        <= 1'b0;
    end else begin
      if (hilowrite[1]) begin
        hi <= wdata;
      end
      if (hilowrite[0]) begin
        lo <= wdata;
      end
      done <= 1'b0;

      case (state_r)
        IDLE: begin
          if (start && !flush) begin
            opLatched_r <= op;
            aLatched_r  <= a;
            bLatched_r  <= b;
            rem_r       <= 32'd0;
            quo_r       <= magnitude(a, ~op[0]);
            divCnt_r    <= 5'd0;
            state_r     <= op[1] ? DIV : MUL;
          end else begin
            state_r <= IDLE;
          end
        end
        MUL: begin
          if (flush) begin
            state_r <= IDLE;
          end else begin
            hi      <= product_s[63:32];
            lo      <= product_s[31:0];
            done    <= 1'b1;
            state_r <= DONE;
          end
        end
        DIV: begin
          if (flush) begin
            state_r <= IDLE;
          end else begin
            rem_r    <= remNext_s;
            quo_r    <= quoNext_s;
            divCnt_r <= divCnt_r + 5'd1;
            if (divCnt_r == 5'd31) begin
              // A zero divisor runs the full sequence but leaves HI/LO alone.
              if (divisor_s != 32'd0) begin
                hi <= remFinal_s;
                lo <= quoFinal_s;
              end
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              state_r <= DIV;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases plus randomized
// operations compared against an arithmetic reference of HI/LO.
module tb_hilo_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic [1:0]  hilowrite;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;
  logic [31:0] expHi;
  logic [31:0] expLo;

  hilo_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hilowrite(hilowrite), .wdata(wdata),
    .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] refResult(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    case (o)
      2'b00: refResult = sx * sy;
      2'b01: refResult = ux * uy;
      2'b10: begin
        if (y == 32'd0) refResult = 64'd0;
        else begin
          q = sx / sy;
          r = sx % sy;
          refResult = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) refResult = 64'd0;
        else begin
          uq = ux / uy;
          ur = ux % uy;
          refResult = {ur[31:0], uq[31:0]};
        end
      end
    endcase
  endfunction

  task automatic applyHw(input logic [1:0] sel, input logic [31:0] d);
    if (sel[1]) expHi = d;
    if (sel[0]) expLo = d;
  endtask

  // Issue one operation; caller is positioned just after a rising edge.
  // flushCyc / hwCyc index cycles from the start cycle (0); -1 means none.
  task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int flushCyc, input int hwCyc,
                       input logic [1:0] hwSel, input logic [31:0] hwData);
    int stallCnt, doneCnt, doneCyc, resCyc;
    bit isMul, flushed, writes;
    logic [63:0] res;
    isMul   = (o[1] == 1'b0);
    resCyc  = isMul ? 1 : 32;
    flushed = (flushCyc >= 0) && (flushCyc <= resCyc);
    writes  = !flushed && (isMul || (y != 32'd0));
    res     = refResult(o, x, y);
    if (hwCyc >= 0 && hwCyc <= resCyc) applyHw(hwSel, hwData);
    if (writes) begin
      expHi = res[63:32];
      expLo = res[31:0];
    end
    if (hwCyc > resCyc) applyHw(hwSel, hwData);

    stallCnt = 0;
    doneCnt  = 0;
    doneCyc  = -1;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    for (int c = 0; c < 36; c++) begin
      flush     = (c == flushCyc);
      hilowrite = (c == hwCyc) ? hwSel : 2'b00;
      wdata     = hwData;
      @(negedge clk);
      if (stall) stallCnt++;
      if (done) begin
        doneCnt++;
        doneCyc = c;
      end
      if (c == flushCyc) checkVal("flush_stall", stall, 1'b0);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    flush     = 1'b0;
    hilowrite = 2'b00;

    checkVal("stall_cycles", stallCnt, flushed ? flushCyc : (isMul ? 2 : 33));
    checkVal("done_count", doneCnt, flushed ? 0 : 1);
    if (!flushed) checkVal("done_cycle", doneCyc, resCyc + 1);
    checkVal("hi", hi, expHi);
    checkVal("lo", lo, expLo);
  endtask

  task automatic writeHiLo(input logic [1:0] sel, input logic [31:0] d);
    hilowrite = sel;
    wdata     = d;
    applyHw(sel, d);
    @(posedge clk);
    #1;
    hilowrite = 2'b00;
  endtask

  initial begin
    logic [1:0]  rOp;
    logic [31:0] rA, rB, rW;
    int          rFlush, rHw;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b1; op = 2'b00; a = 32'd0; b = 32'd0;
    flush = 1'b0; hilowrite = 2'b00; wdata = 32'd0;
    expHi = 32'd0; expLo = 32'd0;

    #2;
    checkVal("rst_hi", hi, 32'd0);
    checkVal("rst_lo", lo, 32'd0);
    checkVal("rst_stall", stall, 1'b0);
    checkVal("rst_done", done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;

    // MULT -3 * 5
    runOp(2'b00, 32'hFFFFFFFD, 32'd5, -1, -1, 2'b00, 32'd0);
    checkVal("mult_hi", hi, 32'hFFFFFFFF);
    checkVal("mult_lo", lo, 32'hFFFFFFF1);
    // DIVU 100 / 7
    runOp(2'b11, 32'd100, 32'd7, -1, -1, 2'b00, 32'd0);
    checkVal("divu_lo", lo, 32'd14);
    checkVal("divu_hi", hi, 32'd2);
    // DIV -7 / 2
    runOp(2'b10, 32'hFFFFFFF9, 32'd2, -1, -1, 2'b00, 32'd0);
    checkVal("div_neg_lo", lo, 32'hFFFFFFFD);
    checkVal("div_neg_hi", hi, 32'hFFFFFFFF);
    // DIV -2^31 / -1 wraps
    runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, -1, -1, 2'b00, 32'd0);
    checkVal("div_ovf_lo", lo, 32'h80000000);
    checkVal("div_ovf_hi", hi, 32'd0);
    // MTHI/MTLO then divide by zero leaves HI/LO alone
    writeHiLo(2'b11, 32'h1234);
    runOp(2'b10, 32'd55, 32'd0, -1, -1, 2'b00, 32'd0);
    checkVal("div0_hi", hi, 32'h1234);
    checkVal("div0_lo", lo, 32'h1234);
    // DIVU flushed on DIV cycle 10
    runOp(2'b11, 32'd999, 32'd3, 10, -1, 2'b00, 32'd0);
    // flush in IDLE suppresses start
    runOp(2'b01, 32'd7, 32'd9, 0, -1, 2'b00, 32'd0);
    // hilowrite in the MUL result cycle loses to the result
    runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1, 2'b11, 32'hDEADBEEF);
    // hilowrite during DIV survives only outside the result cycle
    runOp(2'b11, 32'd1000, 32'd10, -1, 35, 2'b01, 32'hCAFE0001);
    runOp(2'b10, 32'd1000, 32'd0, -1, 32, 2'b10, 32'h5A5A5A5A);

    // Reset on DIV cycle 20, then MULTU on the first edge after release
    start = 1'b1; op = 2'b11; a = 32'd12345; b = 32'd17;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    checkVal("pre_rst_stall", stall, 1'b1);
    rst = 1'b1;
    #1;
    checkVal("async_rst_hi", hi, 32'd0);
    checkVal("async_rst_lo", lo, 32'd0);
    checkVal("async_rst_stall", stall, 1'b0);
    checkVal("async_rst_done", done, 1'b0);
    expHi = 32'd0;
    expLo = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    runOp(2'b01, 32'd3, 32'd4, -1, -1, 2'b00, 32'd0);
    checkVal("multu_lo", lo, 32'd12);
    checkVal("multu_hi", hi, 32'd0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      rOp = 2'($urandom_range(0, 3));
      rA  = $urandom();
      case ($urandom_range(0, 7))
        0:       rB = 32'd0;
        1, 2:    rB = 32'($urandom_range(1, 20));
        3:       rB = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: rB = $urandom();
      endcase
      if ($urandom_range(0, 9) == 0) rA = 32'h80000000;
      rFlush = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 34)) : -1;
      rHw    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 35)) : -1;
      rW     = $urandom();
      runOp(rOp, rA, rB, rFlush, rHw, 2'($urandom_range(1, 3)), rW);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: execute-stage mul/div request.
REQ-004 SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port a, input, 32 bits: rs operand (multiplicand or dividend).
REQ-006 SHALL have port b, input, 32 bits: rt operand (multiplier or divisor).
REQ-007 SHALL have port flush, input, 1 bit: cancels any in-flight operation.
REQ-008 SHALL have port hilowrite, input, 2 bits: bit1 writes HI, bit0 writes LO (MTHI/MTLO).
REQ-009 SHALL have port wdata, input, 32 bits: data for hilowrite.
REQ-010 SHALL have port stall, output, 1 bit: pipeline stall request.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have ports hi and lo, outputs, 32 bits each: registered HI/LO contents.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-014 SHALL, in IDLE with start=1, latch a, b and op at the clock edge and enter MUL (op[1]=0) or DIV (op[1]=1).
REQ-015 SHALL drive stall = (IDLE & start) | MUL | DIV, gated to 0 whenever flush=1.
REQ-016 SHALL, in MUL, write the 64-bit product (signed for MULT, unsigned for MULTU) to {hi,lo} at the end of that cycle and enter DONE; mul latency is 2 cycles from start to DONE.
REQ-017 SHALL perform division as 32-iteration radix-2 restoring division on operand magnitudes, one iteration per DIV cycle, using a 5-bit counter cleared on DIV entry.
REQ-018 SHALL, on the iteration where the counter reaches 31, write lo=quotient and hi=remainder and enter DONE; div latency is 33 cycles from start to DONE.
REQ-019 SHALL, for DIV, negate the quotient when the operand signs differ and give the remainder the sign of the dividend; DIVU treats both operands as unsigned.
REQ-020 SHALL, when the latched divisor is 0, complete the full 33-cycle sequence and leave hi and lo unchanged.
REQ-021 SHALL, in DONE, assert done=1 and stall=0, ignore start, and return to IDLE at the next edge.
REQ-022 SHALL, when flush=1 in MUL or DIV, return to IDLE at the next edge with no HI/LO update and no done pulse.
REQ-023 SHALL, when flush=1 in IDLE, ignore start.
REQ-024 SHALL honour hilowrite in any state, updating the selected register with wdata at the clock edge.
REQ-025 SHALL, when a hilowrite and a result write hit the same register in the same cycle, let the result write win.
REQ-026 SHALL, for -2^31 / -1 under DIV, produce lo=0x80000000 and hi=0 (magnitude wrap, no exception).

Reset
REQ-027 SHALL, on rst=1 at any time including mid-operation, immediately force state=IDLE, counter=0, hi=0, lo=0, done=0, and stall=0 while rst is held.
REQ-028 SHALL, after rst deasserts, accept start on the first rising edge.

Verification
REQ-029 SHALL cover: MULT a=0xFFFFFFFD, b=5 -> stall high 2 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse in cycle 3.
REQ-030 SHALL cover: DIVU a=100, b=7 -> stall high exactly 33 cycles, lo=14, hi=2, one done pulse.
REQ-031 SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; plus a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 SHALL cover: hilowrite=11 with wdata=0x1234 followed by DIV with b=0 -> after 33 cycles hi=lo=0x1234, done pulses.
REQ-033 SHALL cover: DIVU with flush asserted on DIV cycle 10 -> stall drops in that cycle, IDLE next cycle, hi/lo unchanged, no done pulse.
REQ-034 SHALL cover: rst asserted on DIV cycle 20 -> hi=lo=0 and stall=0 asynchronously, then a new MULTU 3*4 gives lo=12, hi=0.
